sync_fifo_pro: RTL
==================

Name: sync_fifo_pro

Overview:
Parametrised synchronous FIFO and the successor to the current fixed 16x8 FIFO. It keeps the same data/handshake/flag port set and adds:
- programmable almost-full and almost-empty thresholds;
- an occupancy count output;
- a synchronous flush;
- a selectable first-word-fall-through (FWFT) read mode.

It sits between a producer and consumer in one clock domain and is driven by the existing randomized transaction bench flow.

Parameters:
FIFO_WIDTH, 16, data word width in bits (>=1)
FIFO_DEPTH, 8, number of entries (>=2; power of two not required)
AF_LEVEL, FIFO_DEPTH-1, almostfull asserts when count >= AF_LEVEL (1..FIFO_DEPTH-1)
AE_LEVEL, 1, almostempty asserts when count <= AE_LEVEL (1..FIFO_DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
CW, $clog2(FIFO_DEPTH+1), count width (derived, not overridable)

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous clear of contents, pointers and count
wr_en  in  1  write request
data_in  in  FIFO_WIDTH  write data
rd_en  in  1  read request (FWFT: acknowledge of head word)
data_out  out  FIFO_WIDTH  read data
wr_ack  out  1  registered; previous-cycle write accepted
overflow  out  1  registered; previous-cycle write rejected because full
underflow  out  1  registered; previous-cycle read rejected because empty
full  out  1  count == FIFO_DEPTH
empty  out  1  count == 0
almostfull  out  1  count >= AF_LEVEL && !full
almostempty  out  1  count <= AE_LEVEL && !empty
count  out  CW  current occupancy

Behaviour:
- Reset (rst=1 at edge): wr_ptr=rd_ptr=0, count=0, data_out=0, wr_ack=0, overflow=0, underflow=0. Memory is not cleared. rst has priority over flush, wr_en and rd_en. A reset mid-burst discards all contents.
- Flush (rst=0, flush=1): same pointer/count clear as reset. data_out holds its value. wr_ack, overflow and underflow are forced to 0. wr_en and rd_en are ignored that cycle.
- Flags are combinational from count, so they are valid in the same cycle count updates.
- Pointers increment modulo FIFO_DEPTH (explicit wrap at FIFO_DEPTH-1 -> 0).
- Write accepted when wr_en && (!full || (rd_en && read accepted)). Accepted: mem[wr_ptr]<=data_in, wr_ptr++, wr_ack=1 next cycle. Rejected: overflow=1 next cycle, nothing stored.
- Read accepted when rd_en && !empty. Not accepted when rd_en && empty: underflow=1 next cycle.
- Empty with wr_en && rd_en: the write is accepted, the read is rejected, underflow=1. There is no bypass of the just-written word.
- Full with wr_en && rd_en: both are accepted and count is unchanged.
- Count: +1 on write-only, -1 on read-only, unchanged on both or neither.
- FWFT=0: on an accepted read, data_out<=mem[rd_ptr] at that edge (1-cycle latency). Otherwise data_out holds.
- FWFT=1: data_out continuously presents mem[rd_ptr] while !empty. An accepted rd_en advances rd_ptr and the next word appears the following cycle. A word written into an empty FIFO appears on data_out 1 cycle after the write edge. While empty, data_out holds the last presented value.
- The threshold parameters are checked at elaboration; an illegal value is a fatal elaboration error.

Test Plan:
1. rst=1 for 2 cycles with wr_en=rd_en=1 -> count=0, empty=1, almostempty=0, full=0, wr_ack=overflow=underflow=0, data_out=0.
2. Defaults, 9 consecutive writes of 0x0001..0x0009 -> wr_ack=1 for the first 8. almostfull=1 at count=7. full=1 at count=8. 9th write gives overflow=1, wr_ack=0, and 0x0009 is not stored.
3. From full, 8 reads with FWFT=0 -> data_out=0x0001..0x0008, each one cycle after its rd_en. almostempty=1 at count=1. A 9th read gives underflow=1 and data_out holds 0x0008.
4. Full FIFO with wr_en=rd_en=1 for 20 cycles, data 0x0100+i -> count stays 8, wr_ack=1 each cycle, no overflow. Output order is preserved across pointer wrap-around.
5. count=5 then flush=1 together with wr_en=1 -> next cycle count=0, empty=1, wr_ack=0. A following write of 0xBEEF then a read returns 0xBEEF.
6. FWFT=1, AF_LEVEL=4, AE_LEVEL=2; write 0xAAAA into empty -> data_out=0xAAAA one cycle later with no rd_en. A further 3 writes give almostfull=1 at count=4. rd_en=1 then advances data_out to the second word next cycle.

Source files
------------

// File: rtl/sync_fifo_pro.sv
// ---------------------------------------------------------------------------
// sync_fifo_pro
//
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, an occupancy count, a synchronous flush and a selectable
// first-word-fall-through (FWFT) read mode.
//
// Ports:
//   clk         rising-edge clock for all logic
//   rst         synchronous active-high reset (highest priority)
//   flush       synchronous clear of pointers and count (data_out holds)
//   wr_en       write request, data_in is stored when accepted
//   data_in     write data
//   rd_en       read request (in FWFT mode: acknowledge of the head word)
//   data_out    read data (registered read, or live head word in FWFT mode)
//   wr_ack      previous-cycle write was accepted
//   overflow    previous-cycle write was rejected because the FIFO was full
//   underflow   previous-cycle read was rejected because the FIFO was empty
//   full        count == FIFO_DEPTH
//   empty       count == 0
//   almostfull  count >= AF_LEVEL and not full
//   almostempty count <= AE_LEVEL and not empty
//   count       current occupancy
// ---------------------------------------------------------------------------
module sync_fifo_pro #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int FWFT       = 0,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CW-1:0]         count
);

  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam bit IS_FWFT = (FWFT != 0);

  // Illegal parameter combinations stop elaboration instead of producing
  // flags that can never (or always) assert.
  if (FIFO_WIDTH < 1) begin : gBadWidth
    $fatal(1, "sync_fifo_pro: FIFO_WIDTH must be >= 1");
  end
  if (FIFO_DEPTH < 2) begin : gBadDepth
    $fatal(1, "sync_fifo_pro: FIFO_DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH - 1) begin : gBadAf
    $fatal(1, "sync_fifo_pro: AF_LEVEL must be in 1..FIFO_DEPTH-1");
  end
  if (AE_LEVEL < 1 || AE_LEVEL > FIFO_DEPTH - 1) begin : gBadAe
    $fatal(1, "sync_fifo_pro: AE_LEVEL must be in 1..FIFO_DEPTH-1");
  end
  if (FWFT != 0 && FWFT != 1) begin : gBadFwft
    $fatal(1, "sync_fifo_pro: FWFT must be 0 or 1");
  end

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PW-1:0]         wrPtr_q, wrPtr_d;
  logic [PW-1:0]         rdPtr_q, rdPtr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [FIFO_WIDTH-1:0] dataOut_q, dataOut_d;
  logic                  wrAck_q, wrAck_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  readOk;
  logic                  writeOk;
  logic                  memWe;
  logic [FIFO_WIDTH-1:0] headWord;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] incPtr(input logic [PW-1:0] ptr);
    return (ptr == PW'(FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Status flags are pure decodes of the occupancy count so they track the
  // count in the same cycle it changes.
  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= CW'(AF_LEVEL)) && !full;
  assign almostempty = (count_q <= CW'(AE_LEVEL)) && !empty;
  assign count       = count_q;

  assign wr_ack    = wrAck_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // A write into a full FIFO is still allowed when a read frees a slot in
  // the same cycle. An empty FIFO never forwards the word being written.
  assign readOk   = rd_en && !empty;
  assign writeOk  = wr_en && (!full || readOk);
  assign headWord = mem[rdPtr_q];

  // In FWFT mode the head word is shown live while data exists; once empty
  // the last shown word is held from the register.
  assign data_out = (IS_FWFT && !empty) ? headWord : dataOut_q;

  // Next-state logic: flush clears pointers/count and suppresses the
  // handshake pulses; otherwise reads and writes are resolved independently
  // and the count moves only when exactly one of them is accepted.
  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    dataOut_d   = dataOut_q;
    wrAck_d     = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    memWe       = 1'b0;

    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (writeOk) begin
        memWe   = 1'b1;
        wrPtr_d = incPtr(wrPtr_q);
        wrAck_d = 1'b1;
      end else if (wr_en) begin
        overflow_d = 1'b1;
      end

      if (readOk) begin
        rdPtr_d = incPtr(rdPtr_q);
      end else if (rd_en) begin
        underflow_d = 1'b1;
      end

      case ({writeOk, readOk})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      if (!IS_FWFT && readOk) begin
        dataOut_d = headWord;
      end
    end

    // FWFT keeps a copy of whatever is currently presented so data_out
    // holds steady when the FIFO drains or is flushed.
    if (IS_FWFT && !empty) begin
      dataOut_d = headWord;
    end
  end

  // State register with synchronous reset; reset wins over flush and
  // any pending read or write.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      dataOut_q   <= '0;
      wrAck_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      dataOut_q   <= dataOut_d;
      wrAck_q     <= wrAck_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array is never cleared; only accepted writes outside reset
  // update it.
  always_ff @(posedge clk) begin
    if (memWe && !rst) begin
      mem[wrPtr_q] <= data_in;
    end
  end

endmodule
